// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and default sizing for the FIFO write arbiter.
// Holds the two-state FSM encoding and default parameter values.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search starting at last+1.
// Ports: req (request vector), last (previous owner) -> win (index), vld.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int OW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      last,
  output logic [OW-1:0]      win,
  output logic               vld
);

  // Offsets run 1..NUM_REQ so the previous owner is tried last.
  always_comb begin
    win = '0;
    vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      logic [OW-1:0] j;
      j = OW'((int'(last) + i) % NUM_REQ);
      if (!vld && req[j]) begin
        vld = 1'b1;
        win = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding a byte FIFO write port.
// Ports: clk/rst, req/req_data/req_last in, gnt/fifo_wr/fifo_data/busy/owner
// out, fifo_full in, stat_beats out (counters only with FIFO_ARB_STATS_EN).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_data,
  input  logic                      fifo_full,
  output logic                      busy,
  output logic [OW-1:0]             owner,
  output logic [NUM_REQ*16-1:0]     stat_beats
);

  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      cnt_nxt;
  logic [OW-1:0]      pick_idx;
  logic               pick_vld;
  logic               beat;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OW      (OW)
  ) u_pick (
    .req  (req),
    .last (owner_q),
    .win  (pick_idx),
    .vld  (pick_vld)
  );

  assign beat    = (state_q == GRANT) && req[owner_q] && !fifo_full;
  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_vld) begin
          state_d         = GRANT;
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          cnt_d           = '0;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (beat) begin
          cnt_d = cnt_nxt;
          if (req_last[owner_q] || cnt_nxt == MAXB) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= OW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset gates the strobe so a burst cut by rst writes nothing more.
  assign fifo_wr   = beat && !rst;
  assign fifo_data = req_data[owner_q*DATA_W +: DATA_W];
  assign gnt       = gnt_q;
  assign busy      = (state_q == GRANT);
  assign owner     = owner_q;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];
  logic [15:0] stat_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i];
    end
    if (fifo_wr && stat_q[owner_q] != 16'hFFFF) begin
      stat_d[owner_q] = stat_q[owner_q] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) stat_q[i] <= '0;
      else     stat_q[i] <= stat_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_beats[g*16 +: 16] = stat_q[g];
  end
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter.
// Covers reset, round-robin, back-pressure, MAX_BURST, abort, reset, stats.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic        busy;
  logic [1:0]  owner;
  logic [63:0] stat_beats;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] wq[$];

  fifo_wr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .gnt        (gnt),
    .fifo_wr    (fifo_wr),
    .fifo_data  (fifo_data),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .owner      (owner),
    .stat_beats (stat_beats)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr === 1'b1) wq.push_back(fifo_data);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset for two cycles.
    tick();
    tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd3);
    chk("rst_wr", fifo_wr, 1'b0);
    chk("rst_stat", stat_beats, 64'd0);

    // Round-robin with 1-beat bursts.
    rst      = 1'b0;
    req      = 4'b1111;
    req_last = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", gnt, 64'(4'b0001 << (k % 4)));
      chk("rr_owner", owner, 64'(k % 4));
      chk("rr_wr", fifo_wr, 1'b1);
      chk("rr_data", fifo_data, 64'(8'h10 + (k % 4)));
      tick();
      chk("rr_idle_gnt", gnt, 4'b0000);
      chk("rr_idle_busy", busy, 1'b0);
      if (k == 4) req = '0;
      tick();
    end
    chk("rr_quiet", gnt, 4'b0000);

    // Back-pressure on requester 2.
    wq.delete();
    req             = 4'b0100;
    req_last        = 4'b0000;
    req_data[23:16] = 8'hA1;
    tick();
    chk("bp_gnt", gnt, 4'b0100);
    chk("bp_wr1", fifo_wr, 1'b1);
    tick();
    req_data[23:16] = 8'hA2;
    fifo_full       = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_stall_wr", fifo_wr, 1'b0);
      tick();
      chk("bp_stall_gnt", gnt, 4'b0100);
    end
    fifo_full = 1'b0;
    #1;
    chk("bp_wr2", fifo_wr, 1'b1);
    tick();
    req_data[23:16] = 8'hA3;
    req_last        = 4'b0100;
    fifo_full       = 1'b1;
    #1;
    chk("bp_full_last_wr", fifo_wr, 1'b0);
    tick();
    chk("bp_full_last_gnt", gnt, 4'b0100);
    chk("bp_full_last_busy", busy, 1'b1);
    fifo_full = 1'b0;
    #1;
    chk("bp_wr3", fifo_wr, 1'b1);
    tick();
    chk("bp_rel_gnt", gnt, 4'b0000);
    req      = '0;
    req_last = '0;
    chk("bp_count", wq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", (i < wq.size()) ? wq[i] : 8'hxx, 64'(8'hA1 + i));
    end

    // MAX_BURST on requester 1, requester 3 waiting.
    wq.delete();
    req_data = {8'h77, 8'h00, 8'h55, 8'h00};
    req      = 4'b0010;
    tick();
    chk("mb_gnt1", gnt, 4'b0010);
    req = 4'b1010;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("mb_hold", gnt, 4'b0010);
      chk("mb_data", fifo_data, 8'h55);
      tick();
    end
    chk("mb_rel", gnt, 4'b0000);
    chk("mb_beats", wq.size(), 16);
    tick();
    chk("mb_next", gnt, 4'b1000);
    chk("mb_owner", owner, 2'd3);

    // Abort of requester 3 before any beat.
    req = 4'b0000;
    #1;
    chk("ab3_wr", fifo_wr, 1'b0);
    tick();
    chk("ab3_gnt", gnt, 4'b0000);

    // Requester 0 drops req mid-burst.
    req = 4'b0001;
    tick();
    chk("ab0_gnt", gnt, 4'b0001);
    tick();
    tick();
    req = 4'b0000;
    #1;
    chk("ab0_wr", fifo_wr, 1'b0);
    tick();
    chk("ab0_rel", gnt, 4'b0000);
    chk("ab0_busy", busy, 1'b0);

    // Reset mid-burst.
    req = 4'b0001;
    tick();
    chk("rb_gnt", gnt, 4'b0001);
    tick();
    rst = 1'b1;
    #1;
    chk("rb_wr_now", fifo_wr, 1'b0);
    tick();
    chk("rb_gnt0", gnt, 4'b0000);
    chk("rb_wr", fifo_wr, 1'b0);
    chk("rb_owner", owner, 2'd3);
    chk("rb_stat", stat_beats, 64'd0);
    rst = 1'b0;
    req = 4'b0000;
    tick();

    // Five beats from requester 3 for the statistics counters.
    req_data = {8'hC3, 8'h00, 8'h00, 8'h00};
    req      = 4'b1000;
    tick();
    chk("st_gnt", gnt, 4'b1000);
    tick();
    tick();
    tick();
    tick();
    req_last = 4'b1000;
    tick();
    chk("st_rel", gnt, 4'b0000);
    req      = '0;
    req_last = '0;
`ifdef FIFO_ARB_STATS_EN
    chk("st_beats", stat_beats, {16'd5, 48'd0});
`else
    chk("st_beats", stat_beats, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
